// File: rtl/hazard_detection_unit_pkg.sv
// rtl/hazard_detection_unit_pkg.sv - shared hazard class bits, class constants and forward encodings
package hazard_detection_unit_pkg;

    localparam int DP_WANT_RS_ID = 7;
    localparam int DP_WANT_RT_ID = 6;
    localparam int DP_NEED_RS_ID = 5;
    localparam int DP_NEED_RT_ID = 4;
    localparam int DP_WANT_RS_EX = 3;
    localparam int DP_WANT_RT_EX = 2;
    localparam int DP_NEED_RS_EX = 1;
    localparam int DP_NEED_RT_EX = 0;

    localparam logic [7:0] HZ_Nothing = 8'h00;
    localparam logic [7:0] HZ_Add     = 8'h0F;
    localparam logic [7:0] HZ_Lw      = 8'h0A;
    localparam logic [7:0] HZ_Sw      = 8'h0A;
    localparam logic [7:0] HZ_Beq     = 8'hF0;

    localparam logic [1:0] FWD_REG  = 2'b00;
    localparam logic [1:0] FWD_MEM  = 2'b01;
    localparam logic [1:0] FWD_WB   = 2'b10;
    localparam logic [1:0] FWD_LINK = 2'b11;

endpackage

// File: rtl/hazard_detection_unit_if.sv
// rtl/hazard_detection_unit_if.sv - pipeline-side hazard inputs and stall/forward outputs
interface hazard_detection_unit_if;
    logic [7:0] DP_Hazards;
    logic [4:0] ID_Rs, ID_Rt, EX_Rs, EX_Rt;
    logic [4:0] EX_RtRd, MEM_RtRd, WB_RtRd;
    logic       EX_Link, EX_RegWrite, MEM_RegWrite, WB_RegWrite;
    logic       MEM_MemRead, MEM_MemWrite;
    logic       InstMem_Read, InstMem_Ready, MEM_Stall_Controller;
    logic       IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall;
    logic [1:0] ID_RsFwdSel, ID_RtFwdSel, EX_RsFwdSel, EX_RtFwdSel;
    logic       MEM_WriteDataFwdSel;

    modport master (
        output DP_Hazards, ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_RtRd, MEM_RtRd, WB_RtRd,
               EX_Link, EX_RegWrite, MEM_RegWrite, WB_RegWrite, MEM_MemRead, MEM_MemWrite,
               InstMem_Read, InstMem_Ready, MEM_Stall_Controller,
        input  IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall,
               ID_RsFwdSel, ID_RtFwdSel, EX_RsFwdSel, EX_RtFwdSel, MEM_WriteDataFwdSel
    );

    modport slave (
        input  DP_Hazards, ID_Rs, ID_Rt, EX_Rs, EX_Rt, EX_RtRd, MEM_RtRd, WB_RtRd,
               EX_Link, EX_RegWrite, MEM_RegWrite, WB_RegWrite, MEM_MemRead, MEM_MemWrite,
               InstMem_Read, InstMem_Ready, MEM_Stall_Controller,
        output IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall,
               ID_RsFwdSel, ID_RtFwdSel, EX_RsFwdSel, EX_RtFwdSel, MEM_WriteDataFwdSel
    );
endinterface

// File: rtl/hazard_detection_unit_fwd_match.sv
// rtl/hazard_detection_unit_fwd_match.sv - one source/destination match term; $0 never matches
module hazard_detection_unit_fwd_match (
    input  logic [4:0] src_i,
    input  logic [4:0] dst_i,
    input  logic       wr_en_i,
    input  logic       use_i,
    output logic       match_o
);
    assign match_o = use_i && wr_en_i && (src_i != 5'd0) && (src_i == dst_i);
endmodule

// File: rtl/hazard_detection_unit.sv
// rtl/hazard_detection_unit.sv - stall/forward decisions for the 5-stage pipeline plus stall-cycle counter
module hazard_detection_unit
    import hazard_detection_unit_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    hazard_detection_unit_if.slave hz,
    output logic [CNT_W-1:0]      Stall_Cycles
);
    // Index 0 is Rs, index 1 is Rt throughout
    logic [4:0] id_src [2];
    logic [4:0] ex_src [2];
    logic [1:0] use_id, need_id, use_ex, need_ex;
    logic [1:0] m_idex, m_idmem, m_idwb, m_exmem, m_exwb;
    logic [1:0] id_sel [2];
    logic [1:0] ex_sel [2];
    logic       mem_op, ex_stall, id_stall;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign id_src[0] = hz.ID_Rs;
    assign id_src[1] = hz.ID_Rt;
    assign ex_src[0] = hz.EX_Rs;
    assign ex_src[1] = hz.EX_Rt;

    assign need_id = {hz.DP_Hazards[DP_NEED_RT_ID], hz.DP_Hazards[DP_NEED_RS_ID]};
    assign need_ex = {hz.DP_Hazards[DP_NEED_RT_EX], hz.DP_Hazards[DP_NEED_RS_EX]};
    assign use_id  = need_id | {hz.DP_Hazards[DP_WANT_RT_ID], hz.DP_Hazards[DP_WANT_RS_ID]};
    assign use_ex  = need_ex | {hz.DP_Hazards[DP_WANT_RT_EX], hz.DP_Hazards[DP_WANT_RS_EX]};

    for (genvar x = 0; x < 2; x++) begin : g_src
        hazard_detection_unit_fwd_match u_idex (
            .src_i(id_src[x]), .dst_i(hz.EX_RtRd), .wr_en_i(hz.EX_RegWrite),
            .use_i(use_id[x]), .match_o(m_idex[x]));
        hazard_detection_unit_fwd_match u_idmem (
            .src_i(id_src[x]), .dst_i(hz.MEM_RtRd), .wr_en_i(hz.MEM_RegWrite),
            .use_i(use_id[x]), .match_o(m_idmem[x]));
        hazard_detection_unit_fwd_match u_idwb (
            .src_i(id_src[x]), .dst_i(hz.WB_RtRd), .wr_en_i(hz.WB_RegWrite),
            .use_i(use_id[x]), .match_o(m_idwb[x]));
        hazard_detection_unit_fwd_match u_exmem (
            .src_i(ex_src[x]), .dst_i(hz.MEM_RtRd), .wr_en_i(hz.MEM_RegWrite),
            .use_i(use_ex[x]), .match_o(m_exmem[x]));
        hazard_detection_unit_fwd_match u_exwb (
            .src_i(ex_src[x]), .dst_i(hz.WB_RtRd), .wr_en_i(hz.WB_RegWrite),
            .use_i(use_ex[x]), .match_o(m_exwb[x]));
    end

    // A memory op in MEM has no ALU result yet, so a needed operand from it must wait
    assign mem_op   = hz.MEM_MemRead | hz.MEM_MemWrite;
    assign ex_stall = hz.MEM_Stall_Controller | (|(m_exmem & need_ex & {2{mem_op}}));
    assign id_stall = ex_stall | (|(m_idex & need_id)) | (|(m_idmem & need_id & {2{mem_op}}));

    assign hz.MEM_Stall = hz.MEM_Stall_Controller;
    assign hz.EX_Stall  = ex_stall;
    assign hz.ID_Stall  = id_stall;
    assign hz.IF_Stall  = id_stall | (hz.InstMem_Read & ~hz.InstMem_Ready);
    assign hz.WB_Stall  = 1'b0;

    // MEM is checked before WB since it holds the newer value
    always_comb begin
        for (int x = 0; x < 2; x++) begin
            id_sel[x] = FWD_REG;
            if (id_src[x] != 5'd0) begin
                if (m_idmem[x])     id_sel[x] = FWD_MEM;
                else if (m_idwb[x]) id_sel[x] = FWD_WB;
            end
            ex_sel[x] = FWD_REG;
            if (hz.EX_Link)                ex_sel[x] = FWD_LINK;
            else if (ex_src[x] != 5'd0) begin
                if (m_exmem[x])     ex_sel[x] = FWD_MEM;
                else if (m_exwb[x]) ex_sel[x] = FWD_WB;
            end
        end
    end

    assign hz.ID_RsFwdSel = id_sel[0];
    assign hz.ID_RtFwdSel = id_sel[1];
    assign hz.EX_RsFwdSel = ex_sel[0];
    assign hz.EX_RtFwdSel = ex_sel[1];
    assign hz.MEM_WriteDataFwdSel = hz.MEM_MemWrite & hz.WB_RegWrite &
                                    (hz.MEM_RtRd != 5'd0) & (hz.MEM_RtRd == hz.WB_RtRd);

    always_comb begin
        cnt_d = cnt_q;
        if (hz.IF_Stall && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign Stall_Cycles = cnt_q;
endmodule

// File: tb/tb_hazard_detection_unit.sv
// tb/tb_hazard_detection_unit.sv - table-driven check of stalls/forwards plus counter sequences
module tb_hazard_detection_unit;
    import hazard_detection_unit_pkg::*;

    localparam logic [8:0] C_LINK = 9'h100, C_EXW = 9'h080, C_MEMW = 9'h040, C_WBW = 9'h020,
                           C_MRD = 9'h010, C_MWR = 9'h008, C_IRD = 9'h004, C_IRDY = 9'h002,
                           C_CTL = 9'h001;
    localparam logic [4:0] S_IF = 5'h10, S_ID = 5'h08, S_EX = 5'h04, S_MEM = 5'h02;

    typedef struct {
        logic [7:0] dp;
        logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_d, mem_d, wb_d;
        logic [8:0] ctl;
        logic [4:0] stl;
        logic [1:0] idrs, idrt, exrs, exrt;
        logic       mwd;
    } vec_t;

    logic       clock, reset;
    logic [3:0] stall_cycles;
    int         n_vec, n_bad;
    vec_t       vt[$];

    hazard_detection_unit_if hz ();

    hazard_detection_unit #(.CNT_W(4)) dut (
        .clock(clock), .reset(reset), .hz(hz), .Stall_Cycles(stall_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(logic [7:0] dp, logic [4:0] id_rs, id_rt, ex_rs, ex_rt,
                                logic [4:0] ex_d, mem_d, wb_d, logic [8:0] ctl, logic [4:0] stl,
                                logic [1:0] idrs, idrt, exrs, exrt, logic mwd);
        vec_t v;
        v.dp = dp; v.id_rs = id_rs; v.id_rt = id_rt; v.ex_rs = ex_rs; v.ex_rt = ex_rt;
        v.ex_d = ex_d; v.mem_d = mem_d; v.wb_d = wb_d; v.ctl = ctl; v.stl = stl;
        v.idrs = idrs; v.idrt = idrt; v.exrs = exrs; v.exrt = exrt; v.mwd = mwd;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        hz.DP_Hazards = v.dp;
        hz.ID_Rs = v.id_rs; hz.ID_Rt = v.id_rt; hz.EX_Rs = v.ex_rs; hz.EX_Rt = v.ex_rt;
        hz.EX_RtRd = v.ex_d; hz.MEM_RtRd = v.mem_d; hz.WB_RtRd = v.wb_d;
        hz.EX_Link = v.ctl[8]; hz.EX_RegWrite = v.ctl[7]; hz.MEM_RegWrite = v.ctl[6];
        hz.WB_RegWrite = v.ctl[5]; hz.MEM_MemRead = v.ctl[4]; hz.MEM_MemWrite = v.ctl[3];
        hz.InstMem_Read = v.ctl[2]; hz.InstMem_Ready = v.ctl[1];
        hz.MEM_Stall_Controller = v.ctl[0];
    endtask

    task automatic check_vec(input int idx, input vec_t v);
        logic [4:0] s;
        s = {hz.IF_Stall, hz.ID_Stall, hz.EX_Stall, hz.MEM_Stall, hz.WB_Stall};
        n_vec++;
        if (s !== v.stl || hz.ID_RsFwdSel !== v.idrs || hz.ID_RtFwdSel !== v.idrt ||
            hz.EX_RsFwdSel !== v.exrs || hz.EX_RtFwdSel !== v.exrt ||
            hz.MEM_WriteDataFwdSel !== v.mwd) begin
            n_bad++;
            $display("FAIL vec%0d: stalls(IF,ID,EX,MEM,WB)=%b/%b idrs=%b/%b idrt=%b/%b exrs=%b/%b exrt=%b/%b mwd=%b/%b (got/want)",
                     idx, s, v.stl, hz.ID_RsFwdSel, v.idrs, hz.ID_RtFwdSel, v.idrt,
                     hz.EX_RsFwdSel, v.exrs, hz.EX_RtFwdSel, v.exrt, hz.MEM_WriteDataFwdSel, v.mwd);
        end
    endtask

    task automatic check_cnt(input string name, input logic [3:0] exp);
        n_vec++;
        if (stall_cycles !== exp) begin
            n_bad++;
            $display("FAIL %s: Stall_Cycles got %0d want %0d", name, stall_cycles, exp);
        end
    endtask

    initial begin
        vec_t idle_v, ifetch_v, loaduse_v;
        n_vec = 0; n_bad = 0;
        reset = 1'b1;

        //        dp          idrs idrt exrs exrt exd  memd wbd  ctl                       stalls                   idrs idrt exrs exrt mwd
        vt.push_back(mk(HZ_Nothing, 0, 0, 0, 0, 0, 0, 0, 9'h000,                      5'h00,                   0, 0, 0, 0, 0));
        vt.push_back(mk(HZ_Add,     0, 0, 1, 3, 0, 1, 0, C_MEMW,                      5'h00,                   0, 0, 1, 0, 0));
        vt.push_back(mk(HZ_Add,     0, 0, 1, 3, 0, 1, 0, C_MEMW|C_MRD,                S_IF|S_ID|S_EX,          0, 0, 1, 0, 0));
        vt.push_back(mk(HZ_Lw,      2, 1, 0, 0, 0, 0, 0, 9'h000,                      5'h00,                   0, 0, 0, 0, 0));
        vt.push_back(mk(HZ_Beq,     5, 0, 0, 0, 5, 0, 0, C_EXW,                       S_IF|S_ID,               0, 0, 0, 0, 0));
        vt.push_back(mk(HZ_Beq,     0, 0, 0, 0, 5, 0, 0, C_EXW,                       5'h00,                   0, 0, 0, 0, 0));
        vt.push_back(mk(HZ_Beq,     0, 0, 0, 0, 0, 0, 0, C_EXW|C_MEMW|C_WBW,          5'h00,                   0, 0, 0, 0, 0));
        vt.push_back(mk(HZ_Nothing, 0, 0, 0, 0, 0, 0, 0, C_LINK,                      5'h00,                   0, 0, 3, 3, 0));
        vt.push_back(mk(HZ_Add,     0, 0, 3, 0, 0, 3, 0, C_LINK|C_MEMW,               5'h00,                   0, 0, 3, 3, 0));
        vt.push_back(mk(HZ_Sw,      0, 0, 0, 0, 0, 7, 7, C_MWR|C_WBW,                 5'h00,                   0, 0, 0, 0, 1));
        vt.push_back(mk(HZ_Nothing, 0, 0, 0, 0, 0, 0, 0, C_MWR|C_WBW,                 5'h00,                   0, 0, 0, 0, 0));
        vt.push_back(mk(HZ_Nothing, 0, 0, 0, 0, 0, 0, 0, C_IRD,                       S_IF,                    0, 0, 0, 0, 0));
        vt.push_back(mk(HZ_Nothing, 0, 0, 0, 0, 0, 0, 0, C_IRD|C_IRDY,                5'h00,                   0, 0, 0, 0, 0));
        vt.push_back(mk(HZ_Nothing, 0, 0, 0, 0, 0, 0, 0, C_CTL,                       S_IF|S_ID|S_EX|S_MEM,    0, 0, 0, 0, 0));
        vt.push_back(mk(HZ_Beq,     4, 6, 0, 0, 0, 4, 6, C_MEMW|C_WBW,                5'h00,                   1, 2, 0, 0, 0));
        vt.push_back(mk(8'hC0,      4, 0, 0, 0, 0, 4, 4, C_MEMW|C_WBW,                5'h00,                   1, 0, 0, 0, 0));
        vt.push_back(mk(HZ_Beq,     9, 0, 0, 0, 0, 9, 0, C_MEMW|C_MRD,                S_IF|S_ID,               1, 0, 0, 0, 0));
        vt.push_back(mk(HZ_Add,     0, 0, 0, 8, 0, 0, 8, C_WBW,                       5'h00,                   0, 0, 0, 2, 0));
        vt.push_back(mk(8'h0C,      0, 0, 1, 0, 0, 1, 0, C_MEMW|C_MRD,                5'h00,                   0, 0, 1, 0, 0));
        vt.push_back(mk(HZ_Add,     0, 0, 3, 0, 0, 3, 3, C_MEMW|C_WBW,                5'h00,                   0, 0, 1, 0, 0));
        vt.push_back(mk(HZ_Add,     0, 0, 3, 0, 0, 3, 0, 9'h000,                      5'h00,                   0, 0, 0, 0, 0));

        // Table runs under reset: combinational outputs must still track the inputs
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i]);
            #1;
            check_vec(i, vt[i]);
            #1;
        end

        idle_v    = vt[0];
        ifetch_v  = vt[11];
        loaduse_v = vt[2];

        drive(idle_v);
        @(negedge clock);
        check_cnt("reset_cnt", 4'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_cnt("idle_no_count", 4'd0);
        drive(ifetch_v);
        repeat (3) @(negedge clock);
        check_cnt("fetch_count", 4'd3);
        drive(loaduse_v);
        repeat (2) @(negedge clock);
        check_cnt("loaduse_count", 4'd5);
        drive(idle_v);
        repeat (2) @(negedge clock);
        check_cnt("hold_count", 4'd5);
        drive(ifetch_v);
        @(negedge clock);
        check_cnt("pre_reset", 4'd6);
        #2 reset = 1'b1;
        #1 check_cnt("async_reset", 4'd0);
        @(negedge clock);
        check_cnt("held_in_reset", 4'd0);
        drive(ifetch_v);
        #1 check_vec(100, ifetch_v);
        reset = 1'b0;
        repeat (14) @(negedge clock);
        check_cnt("count_14", 4'd14);
        @(negedge clock);
        check_cnt("count_15", 4'd15);
        repeat (3) @(negedge clock);
        check_cnt("saturate", 4'd15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_detection_unit.md
Name: hazard_detection_unit

Overview:
- Central hazard unit of the 5-stage MIPS32 pipeline (IF/ID/EX/MEM/WB).
- Compares source registers in ID and EX against destination registers in EX/MEM/WB. Produces per-stage stall signals and forwarding-mux selects for the ID, EX and MEM data paths.
- Stall and forward outputs are purely combinational.
- The only state is a stall-cycle counter, clocked by clock and cleared by reset.

Parameters:
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- DP_Hazards  in  8  hazard class from the ID decoder. Bits: [7] WantRsByID, [6] WantRtByID, [5] NeedRsByID, [4] NeedRtByID, [3] WantRsByEX, [2] WantRtByEX, [1] NeedRsByEX, [0] NeedRtByEX.
- ID_Rs, ID_Rt  in  5  source registers of the instruction in ID.
- EX_Rs, EX_Rt  in  5  source registers of the instruction in EX.
- EX_RtRd, MEM_RtRd, WB_RtRd  in  5  destination register per stage.
- EX_Link  in  1  EX instruction is a link (JAL/BAL etc.).
- EX_RegWrite, MEM_RegWrite, WB_RegWrite  in  1  stage writes the register file.
- MEM_MemRead, MEM_MemWrite  in  1  MEM instruction is a load or store.
- InstMem_Read  in  1  instruction fetch in progress.
- InstMem_Ready  in  1  instruction memory delivered data.
- MEM_Stall_Controller  in  1  data-memory/controller stall request.
- IF_Stall, ID_Stall, EX_Stall, MEM_Stall, WB_Stall  out  1  stage stalls.
- ID_RsFwdSel, ID_RtFwdSel  out  2  ID operand select: 00 regfile, 01 MEM ALU result, 10 WB data.
- EX_RsFwdSel, EX_RtFwdSel  out  2  EX operand select: 00 ID/EX value, 01 MEM result, 10 WB data, 11 link address.
- MEM_WriteDataFwdSel  out  1  store data select: 0 pipeline value, 1 WB data.
- Stall_Cycles  out  CNT_W  number of cycles with IF_Stall high.

Behaviour:
- Definitions, with X in {Rs, Rt}:
  - UseXByID = Want|Need bit of the ID group.
  - UseXByEX = Want|Need bit of the EX group.
- Match terms. Each requires the named source register to be nonzero and equal to the named destination, plus the listed write enable and use bit:
  - X_IDEX = ID_X==EX_RtRd, EX_RegWrite, UseXByID.
  - X_IDMEM = ID_X==MEM_RtRd, MEM_RegWrite, UseXByID.
  - X_IDWB = ID_X==WB_RtRd, WB_RegWrite, UseXByID.
  - X_EXMEM = EX_X==MEM_RtRd, MEM_RegWrite, UseXByEX.
  - X_EXWB = EX_X==WB_RtRd, WB_RegWrite, UseXByEX.
- MEM_Stall = MEM_Stall_Controller.
- EX_Stall = MEM_Stall | any (X_EXMEM & NeedXByEX & (MEM_MemRead|MEM_MemWrite)).
- ID_Stall = EX_Stall | any (X_IDEX & NeedXByID) | any (X_IDMEM & NeedXByID & (MEM_MemRead|MEM_MemWrite)).
- IF_Stall = ID_Stall | (InstMem_Read & ~InstMem_Ready).
- WB_Stall = 0 constant.
- ID_XFwdSel priority: ID_X==0 gives 00; else X_IDMEM gives 01; else X_IDWB gives 10; else 00.
- EX_XFwdSel priority: EX_Link gives 11; else EX_X==0 gives 00; else X_EXMEM gives 01; else X_EXWB gives 10; else 00.
- MEM gets priority over WB in every select, because MEM holds the newer value.
- MEM_WriteDataFwdSel = MEM_MemWrite & WB_RegWrite & (MEM_RtRd!=0) & (MEM_RtRd==WB_RtRd).
- Register $0 never matches, never forwards and never stalls.
- Stall_Cycles:
  - Reset asynchronously to 0.
  - On each rising clock with IF_Stall=1, increments by 1.
  - Saturates at all-ones; no wrap.
- Reset asserted mid-operation clears only the counter. Combinational outputs continue to track the inputs during reset.

Decomposition:
- Shared package/include holds:
  - DP_Hazards bit indices.
  - Hazard class constants: HZ_Nothing=8'h00, HZ_Add=8'h0F (rs,rt want/need by EX), HZ_Lw=8'h0A (rs by EX), HZ_Sw=8'h0A, HZ_Beq=8'hF0 (rs,rt need by ID).
  - Forward-select encodings.
- Natural sub-module: fwd_match, one instance per source/stage pair, computing a match term from source, destination, write enable and use bit.

Test Plan:
- Add hazard: DP=HZ_Add, EX_Rs=1, EX_Rt=3, MEM_RtRd=1, MEM_RegWrite=1, memory ops 0 -> EX_RsFwdSel=01, EX_RtFwdSel=00, all stalls 0, counter unchanged.
- Load-use: same as above plus MEM_MemRead=1 -> MEM_Stall=0, EX_Stall=1, ID_Stall=1, IF_Stall=1, WB_Stall=0; Stall_Cycles increments each clock.
- No-match load: DP=HZ_Lw, ID_Rs=2, ID_Rt=1, all destinations/enables 0 -> all stalls 0, all FwdSel 00, MEM_WriteDataFwdSel=0.
- Branch in ID: DP=HZ_Beq, ID_Rs=5, EX_RtRd=5, EX_RegWrite=1 -> ID_Stall=1, IF_Stall=1, EX_Stall=0. Same case with ID_Rs=0 -> no stall.
- Link/store: EX_Link=1 -> EX_RsFwdSel=EX_RtFwdSel=11. MEM_MemWrite=1, WB_RegWrite=1, MEM_RtRd=WB_RtRd=7 -> MEM_WriteDataFwdSel=1.
- Fetch/controller/reset: InstMem_Read=1, InstMem_Ready=0 -> IF_Stall=1 only. MEM_Stall_Controller=1 -> MEM_Stall, EX_Stall, ID_Stall, IF_Stall all 1. Reset pulse mid-run -> Stall_Cycles=0 immediately.
